// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
//   Bundles the keypad matrix lines and the decoded key outputs of keypad_scanner.
//   row       : keypad rows, active-low, asynchronous to the scanner clock
//   col       : keypad columns, active-low, one column driven low at a time
//   key_code  : last accepted key, row_idx*4 + col_idx
//   key_valid : one-clock strobe, new key accepted
//   key_held  : high while the accepted key is still considered pressed
//   modport master : the scanner side (drives columns and key outputs)
//   modport slave  : the keypad/consumer side
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column per prescaler period, gathers
//   four column samples into a frame, and debounces frames into a single
//   key_code/key_valid event per press, with key_held tracking the press.
//   clock : system clock
//   reset : asynchronous, active-low reset
//   bus   : keypad_scanner_if.master (row in; col, key_code, key_valid, key_held out)
module keypad_scanner #(
    parameter int PRESCALER_WIDTH = 18,
    parameter int SCAN_LIMIT      = 200000,
    parameter int DEBOUNCE_SCANS  = 4
) (
    input  logic              clock,
    input  logic              reset,
    keypad_scanner_if.master  bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] DEB_PRESS   = 2'd1;
    localparam logic [1:0] PRESSED     = 2'd2;
    localparam logic [1:0] DEB_RELEASE = 2'd3;

    logic [3:0]                 sync1_q, sync1_d, sync2_q, sync2_d;
    logic [PRESCALER_WIDTH-1:0] presc_q, presc_d;
    logic [1:0]                 col_idx_q, col_idx_d;
    logic [1:0]                 hit_cnt_q, hit_cnt_d;    // 0, 1, or 2 meaning "two or more"
    logic [3:0]                 hit_code_q, hit_code_d;
    logic [1:0]                 state_q, state_d;
    logic [3:0]                 cand_q, cand_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [3:0]                 key_code_q, key_code_d;
    logic                       key_valid_q, key_valid_d;
    logic                       key_held_q, key_held_d;

    logic       tick, frame_close, f_none, f_single;
    logic [2:0] n_low, sum;
    logic [1:0] frame_cnt;
    logic [3:0] samp_code, frame_code;

    always_comb begin
        sync1_d = bus.row;
        sync2_d = sync1_q;

        tick        = (presc_q == PRESCALER_WIDTH'(SCAN_LIMIT - 1));
        frame_close = tick && (col_idx_q == 2'd3);
        presc_d     = tick ? '0 : presc_q + PRESCALER_WIDTH'(1);
        col_idx_d   = tick ? col_idx_q + 2'd1 : col_idx_q;

        // Low rows in the current column sample; the code is only meaningful when one is low.
        n_low     = '0;
        samp_code = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            if (!sync2_q[r]) begin
                n_low     = n_low + 3'd1;
                samp_code = {2'(r), col_idx_q};
            end
        end

        // Frame tally including the column being sampled on this tick, saturating at 2.
        sum        = {1'b0, hit_cnt_q} + n_low;
        frame_cnt  = (sum > 3'd1) ? 2'd2 : sum[1:0];
        frame_code = (hit_cnt_q == 2'd1) ? hit_code_q : samp_code;
        f_none     = (frame_cnt == 2'd0);
        f_single   = (frame_cnt == 2'd1);

        hit_cnt_d  = hit_cnt_q;
        hit_code_d = hit_code_q;
        if (frame_close) begin
            hit_cnt_d  = '0;
            hit_code_d = '0;
        end else if (tick) begin
            hit_cnt_d  = frame_cnt;
            hit_code_d = frame_code;
        end

        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        if (frame_close) begin
            case (state_q)
                IDLE: begin
                    if (f_single) begin
                        cand_d = frame_code;
                        if (DEBOUNCE_SCANS == 1) begin
                            key_code_d  = frame_code;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            cnt_d       = '0;
                            state_d     = PRESSED;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = DEB_PRESS;
                        end
                    end
                end
                DEB_PRESS: begin
                    if (f_single && (frame_code == cand_q)) begin
                        if ((cnt_q + CNT_W'(1)) == CNT_W'(DEBOUNCE_SCANS)) begin
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            cnt_d       = '0;
                            state_d     = PRESSED;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                PRESSED: begin
                    // Any key activity keeps the press alive; only empty frames lead to release.
                    if (f_none) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            key_held_d = 1'b0;
                            cnt_d      = '0;
                            state_d    = IDLE;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = DEB_RELEASE;
                        end
                    end
                end
                default: begin // DEB_RELEASE
                    if (f_none) begin
                        if ((cnt_q + CNT_W'(1)) == CNT_W'(DEBOUNCE_SCANS)) begin
                            key_held_d = 1'b0;
                            cnt_d      = '0;
                            state_d    = IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = PRESSED;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            presc_q     <= '0;
            col_idx_q   <= '0;
            hit_cnt_q   <= '0;
            hit_code_q  <= '0;
            state_q     <= IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            presc_q     <= presc_d;
            col_idx_q   <= col_idx_d;
            hit_cnt_q   <= hit_cnt_d;
            hit_code_q  <= hit_code_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign bus.col       = ~(4'b0001 << col_idx_q);
    assign bus.key_code  = key_code_q;
    assign bus.key_valid = key_valid_q;
    assign bus.key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    keypad_scanner_if kif();

    keypad_scanner #(
        .PRESCALER_WIDTH(18),
        .SCAN_LIMIT(4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(kif)
    );

    // Keypad model: pressed[r*4+c] pulls row r low while column c is driven low.
    logic [15:0] pressed = '0;
    always_comb begin
        kif.row = 4'hF;
        for (int unsigned r = 0; r < 4; r++)
            for (int unsigned c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kif.col[c]) kif.row[r] = 1'b0;
    end

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int pulses = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: counts pulses and flags a strobe wider than one clock.
    always @(negedge clock) begin
        if (kif.key_valid === 1'b1) begin
            pulses++;
            check("valid_width", 32'(prev_valid), 32'd0);
        end
        prev_valid = kif.key_valid;
    end

    // Returns on the negedge right after a frame-closing edge (col 0111 -> 1110).
    task automatic wait_frame();
        logic [3:0] last;
        bit done;
        last = kif.col;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clock);
            if (last == 4'b0111 && kif.col == 4'b1110) done = 1'b1;
            last = kif.col;
        end
        if (!done) check("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic frame_chk(input string tag, input logic ev, input logic eh, input logic [3:0] ec);
        wait_frame();
        check({tag, "_valid"}, 32'(kif.key_valid), 32'(ev));
        check({tag, "_held"},  32'(kif.key_held),  32'(eh));
        check({tag, "_code"},  32'(kif.key_code),  32'(ec));
    endtask

    logic [3:0] col_seq [5];

    initial begin
        col_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

        // 1: reset state and idle column walk
        repeat (3) @(negedge clock);
        check("rst_col",   32'(kif.col),       32'hE);
        check("rst_code",  32'(kif.key_code),  32'h0);
        check("rst_valid", 32'(kif.key_valid), 32'h0);
        check("rst_held",  32'(kif.key_held),  32'h0);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("col_seq", 32'(kif.col), 32'(col_seq[k]));
            check("idle_valid", 32'(kif.key_valid), 32'h0);
            repeat (4) @(negedge clock);
        end
        check("idle_held", 32'(kif.key_held), 32'h0);
        wait_frame();

        // 2: hold (r2,c1) -> one pulse with code 9 on the third frame
        pressed[9] = 1'b1;
        frame_chk("p9_f1", 1'b0, 1'b0, 4'd0);
        frame_chk("p9_f2", 1'b0, 1'b0, 4'd0);
        frame_chk("p9_f3", 1'b1, 1'b1, 4'd9);
        frame_chk("p9_f4", 1'b0, 1'b1, 4'd9);
        frame_chk("p9_f5", 1'b0, 1'b1, 4'd9);

        // 4b: add (r0,c0) while 9 is held -> no event
        pressed[0] = 1'b1;
        frame_chk("p9m_f1", 1'b0, 1'b1, 4'd9);
        frame_chk("p9m_f2", 1'b0, 1'b1, 4'd9);

        // 5: one empty frame then press again, then a full release
        pressed = '0;
        frame_chk("rel1", 1'b0, 1'b1, 4'd9);
        pressed[9] = 1'b1;
        frame_chk("repress", 1'b0, 1'b1, 4'd9);
        pressed = '0;
        frame_chk("rel_f1", 1'b0, 1'b1, 4'd9);
        frame_chk("rel_f2", 1'b0, 1'b1, 4'd9);
        frame_chk("rel_f3", 1'b0, 1'b0, 4'd9);

        // 3: (r0,c3) two frames, gap, then three frames -> code 3
        pressed[3] = 1'b1;
        frame_chk("p3_a1", 1'b0, 1'b0, 4'd9);
        frame_chk("p3_a2", 1'b0, 1'b0, 4'd9);
        pressed = '0;
        frame_chk("p3_gap", 1'b0, 1'b0, 4'd9);
        pressed[3] = 1'b1;
        frame_chk("p3_b1", 1'b0, 1'b0, 4'd9);
        frame_chk("p3_b2", 1'b0, 1'b0, 4'd9);
        frame_chk("p3_b3", 1'b1, 1'b1, 4'd3);
        pressed = '0;
        frame_chk("p3_r1", 1'b0, 1'b1, 4'd3);
        frame_chk("p3_r2", 1'b0, 1'b1, 4'd3);
        frame_chk("p3_r3", 1'b0, 1'b0, 4'd3);

        // 4a: two keys together never produce an event
        pressed[5]  = 1'b1;
        pressed[14] = 1'b1;
        for (int k = 0; k < 4; k++) frame_chk("multi", 1'b0, 1'b0, 4'd3);
        pressed = '0;
        frame_chk("multi_rel", 1'b0, 1'b0, 4'd3);

        // 6: reset during DEB_PRESS, key kept pressed across reset
        pressed[9] = 1'b1;
        frame_chk("r6_f1", 1'b0, 1'b0, 4'd3);
        frame_chk("r6_f2", 1'b0, 1'b0, 4'd3);
        repeat (6) @(negedge clock);
        reset = 1'b0;
        #1;
        check("r6_col",   32'(kif.col),       32'hE);
        check("r6_code",  32'(kif.key_code),  32'h0);
        check("r6_valid", 32'(kif.key_valid), 32'h0);
        check("r6_held",  32'(kif.key_held),  32'h0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        frame_chk("r6_n1", 1'b0, 1'b0, 4'd0);
        frame_chk("r6_n2", 1'b0, 1'b0, 4'd0);
        frame_chk("r6_n3", 1'b1, 1'b1, 4'd9);
        pressed = '0;
        frame_chk("r6_r1", 1'b0, 1'b1, 4'd9);
        frame_chk("r6_r2", 1'b0, 1'b1, 4'd9);
        frame_chk("r6_r3", 1'b0, 1'b0, 4'd9);

        check("pulse_total", 32'(pulses), 32'd3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
